debouncer_array: RTL and testbench

- Parametrised, multi-channel successor to the single-input debouncer. Debounces CHANNELS independent asynchronous inputs (buttons, switches) in the clock_100mhz domain.
- Each channel has a two-flop synchroniser, a configurable stability window, a programmable reset level, and single-cycle rise/fall event pulses.
- Sits between board I/O pins and the control logic that consumes key presses.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 53 +++++
 rtl/debouncer_array.sv | 44 ++++
 tb/tb_debouncer_array.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debouncer family.
package debounce_pkg;

  localparam int unsigned CLOCK_HZ              = 100000000;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;

  // Convert a stability window in milliseconds to clock_100mhz cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLOCK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, stability counter, level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clock_100mhz,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept_c
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Accept fires when the synchronised input has differed for the full window.
  assign accept_c = (sync2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      level <= RESET_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept_c) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debouncer_array.sv
// Multi-channel debouncer: independent channels plus a shared any_change pulse.
module debouncer_array
  import debounce_pkg::*;
#(
  parameter int unsigned          CHANNELS      = 4,
  parameter int unsigned          STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [CHANNELS-1:0]  RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                clock_100mhz,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  logic [CHANNELS-1:0] accept_c;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_VALUE[i])
    ) u_ch (
      .clock_100mhz (clock_100mhz),
      .reset_n      (reset_n),
      .raw          (raw[i]),
      .level        (debounced[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .accept_c     (accept_c[i])
    );
  end

  // Registered from the accept strobes so it lines up with rise/fall.
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept_c;
    end
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Directed bench for debouncer_array with STABLE_CYCLES=4 (two instances, reset levels 0000 and 1010).
module tb_debouncer_array;

  logic       clock_100mhz = 1'b0;
  logic       reset_n;
  logic [3:0] raw;
  logic [3:0] debounced, rise, fall;
  logic       any_change;
  logic [3:0] raw_b;
  logic [3:0] debounced_b, rise_b, fall_b;
  logic       any_change_b;

  int checks = 0;
  int errors = 0;

  int rise_cnt [4];
  int fall_cnt [4];
  int ac_cnt   = 0;
  int b_pulses = 0;

  always #5 clock_100mhz = ~clock_100mhz;

  debouncer_array #(.CHANNELS(4), .STABLE_CYCLES(4), .RESET_VALUE(4'b0000)) dut (
    .clock_100mhz (clock_100mhz),
    .reset_n      (reset_n),
    .raw          (raw),
    .debounced    (debounced),
    .rise         (rise),
    .fall         (fall),
    .any_change   (any_change)
  );

  debouncer_array #(.CHANNELS(4), .STABLE_CYCLES(4), .RESET_VALUE(4'b1010)) dut_b (
    .clock_100mhz (clock_100mhz),
    .reset_n      (reset_n),
    .raw          (raw_b),
    .debounced    (debounced_b),
    .rise         (rise_b),
    .fall         (fall_b),
    .any_change   (any_change_b)
  );

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  end

  // Pulse counters sampled mid-cycle, once per clock.
  always @(negedge clock_100mhz) begin
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) rise_cnt[i] <= rise_cnt[i] + 1;
      if (fall[i]) fall_cnt[i] <= fall_cnt[i] + 1;
    end
    if (any_change) ac_cnt <= ac_cnt + 1;
    if ((|rise_b) || (|fall_b) || any_change_b) b_pulses <= b_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock_100mhz);
      #1;
    end
  endtask

  int snap_ac, snap_r, snap_f;

  initial begin
    reset_n = 1'b0;
    raw     = 4'b0000;
    raw_b   = 4'b1010;
    tick(3);
    check("reset_debounced", 32'(debounced), 32'h0);
    check("reset_pulses", 32'({rise, fall, any_change}), 32'h0);
    check("reset_b_debounced", 32'(debounced_b), 32'ha);
    reset_n = 1'b1;

    // 1: single channel accepted on edge 5
    snap_ac = ac_cnt;
    raw = 4'b0001;
    tick(5);
    check("t1_before_accept", 32'(debounced), 32'h0);
    tick(1);
    check("t1_debounced", 32'(debounced), 32'h1);
    check("t1_rise", 32'(rise), 32'h1);
    check("t1_fall", 32'(fall), 32'h0);
    check("t1_any_change", 32'(any_change), 32'h1);
    tick(1);
    check("t1_rise_clear", 32'(rise), 32'h0);
    check("t1_any_clear", 32'(any_change), 32'h0);
    tick(2);
    check("t1_any_count", 32'(ac_cnt - snap_ac), 32'h1);

    // 2: 3-cycle glitch rejected, then a held level accepted
    snap_r = rise_cnt[1];
    raw = 4'b0011;
    tick(3);
    raw = 4'b0001;
    tick(10);
    check("t2_glitch_level", 32'(debounced), 32'h1);
    check("t2_glitch_rise", 32'(rise_cnt[1] - snap_r), 32'h0);
    raw = 4'b0011;
    tick(5);
    check("t2_before_accept", 32'(debounced), 32'h1);
    tick(1);
    check("t2_debounced", 32'(debounced), 32'h3);
    check("t2_rise", 32'(rise), 32'h2);

    // 3: chatter on channel 2, then held high
    tick(2);
    snap_r = rise_cnt[2];
    snap_f = fall_cnt[2];
    for (int p = 0; p < 10; p++) begin
      raw[2] = 1'b1;
      tick(2);
      raw[2] = 1'b0;
      tick(2);
    end
    check("t3_chatter_level", 32'(debounced), 32'h3);
    raw[2] = 1'b1;
    tick(5);
    check("t3_before_accept", 32'(debounced), 32'h3);
    tick(1);
    check("t3_debounced", 32'(debounced), 32'h7);
    check("t3_rise", 32'(rise), 32'h4);
    tick(4);
    check("t3_rise_count", 32'(rise_cnt[2] - snap_r), 32'h1);
    check("t3_fall_count", 32'(fall_cnt[2] - snap_f), 32'h0);

    // 4: all channels high, then simultaneous fall
    raw = 4'b1111;
    tick(6);
    check("t4_all_high", 32'(debounced), 32'hf);
    check("t4_rise3", 32'(rise), 32'h8);
    tick(3);
    snap_ac = ac_cnt;
    raw = 4'b0000;
    tick(5);
    check("t4_before_fall", 32'(fall), 32'h0);
    tick(1);
    check("t4_fall", 32'(fall), 32'hf);
    check("t4_debounced", 32'(debounced), 32'h0);
    check("t4_any_change", 32'(any_change), 32'h1);
    tick(1);
    check("t4_fall_clear", 32'(fall), 32'h0);
    check("t4_any_clear", 32'(any_change), 32'h0);
    tick(3);
    check("t4_any_count", 32'(ac_cnt - snap_ac), 32'h1);

    // 5: asynchronous reset mid-count
    raw = 4'b0001;
    tick(6);
    check("t5_pre_level", 32'(debounced), 32'h1);
    raw = 4'b1001;
    tick(4);
    reset_n = 1'b0;
    #2;
    check("t5_async_debounced", 32'(debounced), 32'h0);
    check("t5_async_pulses", 32'({rise, fall, any_change}), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check("t5_before_accept", 32'(debounced), 32'h0);
    tick(1);
    check("t5_debounced", 32'(debounced), 32'h9);
    check("t5_rise", 32'(rise), 32'h9);

    // 6: reset level 1010 instance held at its reset value
    tick(100);
    check("t6_debounced_b", 32'(debounced_b), 32'ha);
    check("t6_b_pulses", 32'(b_pulses), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
